// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reader feeding a byte prefetch queue
// that presents a little-endian instruction window to a variable-length decoder.
module fetch_unit #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 8,
    parameter int unsigned   IW       = 32,
    parameter int unsigned   DEPTH    = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [AW-1:0]                redirect_pc,
    input  logic                         pop,
    input  logic [$clog2(IW/DW+1)-1:0]   pop_len,
    output logic [$clog2(DEPTH+1)-1:0]   avail,
    output logic [IW-1:0]                ins_data,
    output logic [AW-1:0]                ins_pc,
    output logic                         mem_req,
    output logic [AW-1:0]                mem_addr,
    input  logic                         mem_ack,
    input  logic [DW-1:0]                mem_rdata
);

    localparam int unsigned LANES = IW / DW;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [AW-1:0]   fetch_pc, fetch_pc_next, ins_pc_next, addr_next;
    logic            req_next, ack, push, pop_ok;
    logic [DW-1:0]   q [DEPTH];

    assign avail = count;

    always_comb begin
        ack    = mem_req & mem_ack;
        push   = (state == FETCH) & ack & ~redirect;
        pop_ok = pop && (pop_len != '0) && (CW'(pop_len) <= count);

        if (redirect) begin
            count_next    = '0;
            fetch_pc_next = redirect_pc;
            ins_pc_next   = redirect_pc;
        end else begin
            count_next    = count + CW'(push) - (pop_ok ? CW'(pop_len) : '0);
            fetch_pc_next = fetch_pc + AW'(push);
            ins_pc_next   = pop_ok ? ins_pc + AW'(pop_len) : ins_pc;
        end

        state_next = state;
        req_next   = mem_req;
        addr_next  = mem_addr;
        // Any completed (or squashed) beat, or sitting idle, is a chance to issue the next read;
        // an unacked request must hold its address, so a redirect there only marks it squashed.
        if (state == IDLE || ack) begin
            if (count_next < CW'(DEPTH)) begin
                state_next = FETCH;
                req_next   = 1'b1;
                addr_next  = fetch_pc_next;
            end else begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        end else if (redirect) begin
            state_next = SQUASH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ins_pc   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            mem_req  <= req_next;
            mem_addr <= addr_next;
            count    <= count_next;
            ins_pc   <= ins_pc_next;
            fetch_pc <= fetch_pc_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)   wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok) rd_ptr <= rd_ptr + PW'(pop_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= mem_rdata;
    end

    always_comb begin
        ins_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(count)) ins_data[k*DW +: DW] = q[rd_ptr + PW'(k)];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked every cycle
// against a byte-queue model of the fetch stream.
module tb_fetch_unit;

    localparam int DEPTH = 8;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst, redirect, pop, mem_ack, mem_req;
    logic [15:0] redirect_pc, ins_pc, mem_addr;
    logic [2:0]  pop_len;
    logic [3:0]  avail;
    logic [31:0] ins_data;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    fetch_unit #(.AW(16), .DW(8), .IW(32), .DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .pop(pop), .pop_len(pop_len), .avail(avail), .ins_data(ins_data), .ins_pc(ins_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: bytes expected in the queue, head PC, next address to fetch, pending squash.
    logic [7:0]  mq[$];
    logic [15:0] hpc, exp_fetch, sq_addr;
    bit          squash;
    int          wait_cnt, lat;
    bit          rand_lat, ack_en, spur;

    function automatic logic [7:0] dat(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hpc       = 16'h0000;
        exp_fetch = 16'h0000;
        sq_addr   = 16'h0000;
        squash    = 1'b0;
        wait_cnt  = 0;
    endtask

    task automatic compare_all();
        logic [31:0] exp_data;
        exp_data = '0;
        for (int k = 0; k < LANES; k++)
            if (k < mq.size()) exp_data[8*k +: 8] = mq[k];
        chk("avail", 32'(avail), mq.size());
        chk("ins_pc", 32'(ins_pc), 32'(hpc));
        chk("ins_data", ins_data, exp_data);
        chk("mem_req", 32'(mem_req), 32'(mq.size() < DEPTH));
        if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(squash ? sq_addr : exp_fetch));
    endtask

    // Called at a falling edge: drive inputs, advance the model, then check after the rising edge.
    task automatic step(input bit r, input logic [15:0] rpc, input bit p, input logic [2:0] plen);
        bit          a, pre_req, ackd;
        logic [15:0] pre_addr;
        int          n;
        pre_req  = mem_req;
        pre_addr = mem_addr;
        a = ack_en && (pre_req ? (wait_cnt >= lat) : (spur && $urandom_range(0, 3) == 0));
        redirect    = r;
        redirect_pc = rpc;
        pop         = p;
        pop_len     = plen;
        mem_ack     = a;
        mem_rdata   = pre_req ? dat(pre_addr) : 8'($urandom);
        ackd = pre_req && a;
        if (r) begin
            mq.delete();
            hpc       = rpc;
            exp_fetch = rpc;
            squash    = pre_req && !ackd;
            sq_addr   = pre_addr;
        end else begin
            n = int'(plen);
            if (p && n >= 1 && n <= mq.size()) begin
                repeat (n) void'(mq.pop_front());
                hpc += 16'(n);
            end
            if (ackd) begin
                if (squash) squash = 1'b0;
                else begin
                    mq.push_back(dat(exp_fetch));
                    exp_fetch++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!pre_req || a) begin
            wait_cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
            wait_cnt++;
        end
        compare_all();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_req"},  32'(mem_req),  32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_avail"},    32'(avail),    32'h0);
        chk({tag, "_ins_data"}, ins_data,      32'h0);
        chk({tag, "_ins_pc"},   32'(ins_pc),   32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit          found, r, p;
        logic [15:0] rpc;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; pop = 1'b0; pop_len = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        lat = 0; rand_lat = 1'b0; ack_en = 1'b1; spur = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Zero-wait fill from reset
        step(0, 16'h0, 0, 3'd0);
        chk("t1_first_req", 32'(mem_req), 32'h1);
        chk("t1_first_addr", 32'(mem_addr), 32'h0);
        repeat (8) step(0, 16'h0, 0, 3'd0);
        chk("t1_idle", 32'(mem_req), 32'h0);
        chk("t1_avail", 32'(avail), 32'd8);
        chk("t1_window", ins_data, 32'h03020100);
        chk("t1_pc", 32'(ins_pc), 32'h0);

        // Pop three from a full queue
        step(0, 16'h0, 1, 3'd3);
        chk("t2_avail", 32'(avail), 32'd5);
        chk("t2_pc", 32'(ins_pc), 32'd3);
        chk("t2_window", ins_data, 32'h06050403);
        chk("t2_req", 32'(mem_req), 32'h1);
        chk("t2_addr", 32'(mem_addr), 32'd8);

        // Slow memory, redirect during the wait
        lat = 3;
        step(0, 16'h0, 0, 3'd0);
        step(1, 16'h4000, 0, 3'd0);
        chk("t3_hold_addr", 32'(mem_addr), 32'd8);
        chk("t3_avail", 32'(avail), 32'd0);
        chk("t3_pc", 32'(ins_pc), 32'h4000);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 16'h0, 0, 3'd0);
            if (mem_addr == 16'h4000) found = 1'b1;
        end
        chk("t3_reach_4000", 32'(found), 32'h1);
        chk("t3_avail_after_squash", 32'(avail), 32'd0);
        for (int i = 0; i < 8 && avail == 0; i++) step(0, 16'h0, 0, 3'd0);
        chk("t3_first_byte_avail", 32'(avail), 32'd1);
        chk("t3_first_byte", ins_data, 32'h00000040);

        // Redirect + pop + ack together
        lat = 0;
        repeat (3) step(0, 16'h0, 0, 3'd0);
        step(1, 16'h1234, 1, 3'd1);
        chk("t4_avail", 32'(avail), 32'd0);
        chk("t4_pc", 32'(ins_pc), 32'h1234);
        chk("t4_addr", 32'(mem_addr), 32'h1234);
        step(0, 16'h0, 0, 3'd0);
        chk("t4_next_byte", ins_data, 32'h00000026);

        // Address wrap
        step(1, 16'hFFFE, 0, 3'd0);
        chk("t5_addr_fffe", 32'(mem_addr), 32'hFFFE);
        step(0, 16'h0, 0, 3'd0);
        step(0, 16'h0, 0, 3'd0);
        chk("t5_addr_wrap", 32'(mem_addr), 32'h0000);
        step(0, 16'h0, 0, 3'd0);
        chk("t5_window", ins_data, 32'h00000001);
        step(0, 16'h0, 1, 3'd2);
        chk("t5_pc_wrap", 32'(ins_pc), 32'h0000);

        // Oversized pop ignored, then reset mid-fetch
        step(1, 16'h0100, 0, 3'd0);
        step(0, 16'h0, 0, 3'd0);
        step(0, 16'h0, 0, 3'd0);
        ack_en = 1'b0;
        step(0, 16'h0, 1, 3'd3);
        chk("t6_avail_kept", 32'(avail), 32'd2);
        chk("t6_mid_fetch", 32'(mem_req), 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset("t6_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        step(0, 16'h0, 0, 3'd0);
        chk("t6_restart_req", 32'(mem_req), 32'h1);

        // Randomized traffic
        rand_lat = 1'b1;
        spur = 1'b1;
        repeat (3000) begin
            r   = ($urandom_range(0, 99) < 3);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            p   = ($urandom_range(0, 9) < 4);
            step(r, rpc, p, 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
